// File: rtl/mult4_share_seq_if.sv
// Bundle between requesters, result consumer and the shared 4x4 multiplier core.
// Handshakes: a transfer happens on a rising edge where valid and ready are both high; valid and payload hold until then.
interface mult4_share_seq_if #(
  parameter int NREQ = 2,
  parameter int ID_W = 2
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [8*NREQ-1:0] req_a;
  logic [8*NREQ-1:0] req_b;
  logic              res_valid;
  logic              res_ready;
  logic [15:0]       res_prod;
  logic [ID_W-1:0]   res_id;
  logic [3:0]        core_x;
  logic [3:0]        core_y;
  logic [7:0]        core_o;

  modport slave (
    input  req_valid, req_a, req_b, res_ready, core_o,
    output req_ready, res_valid, res_prod, res_id, core_x, core_y
  );

  modport master (
    output req_valid, req_a, req_b, res_ready, core_o,
    input  req_ready, res_valid, res_prod, res_id, core_x, core_y
  );
endinterface

// File: rtl/mult4_share_seq.sv
// Round-robin sequencer computing 8x8 products as four nibble partial products
// on one external 4x4 multiplier, returning the product tagged with the requester id.
module mult4_share_seq #(
  parameter int NREQ = 2,
  parameter int ID_W = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mult4_share_seq_if.slave     bus,
  output logic                 busy,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      step_q, step_d;
  logic [15:0]     acc_q, acc_d;
  logic [ID_W-1:0] last_grant_q, last_grant_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [7:0]      a_q, a_d;
  logic [7:0]      b_q, b_d;

  logic            grant_found;
  logic [ID_W-1:0] grant_idx;
  logic [NREQ-1:0] rot_valid;
  int              cand;
  logic [15:0]     partial;

  // Search from the requester after the last grant, wrapping at NREQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    rot_valid   = '0;
    cand        = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cand      = (int'(last_grant_q) + k) % NREQ;
      rot_valid = bus.req_valid >> cand;
      if (!grant_found && rot_valid[0]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(cand);
      end
    end
  end

  // Core operands decode only from registered state so core_o settles within the cycle.
  assign bus.core_x = (state_q == MUL) ? (step_q[0] ? a_q[7:4] : a_q[3:0]) : 4'h0;
  assign bus.core_y = (state_q == MUL) ? (step_q[1] ? b_q[7:4] : b_q[3:0]) : 4'h0;

  always_comb begin
    case (step_q)
      2'd0:    partial = {8'h00, bus.core_o};
      2'd3:    partial = {bus.core_o, 8'h00};
      default: partial = {4'h0, bus.core_o, 4'h0};
    endcase
  end

  always_comb begin
    state_d      = state_q;
    step_d       = step_q;
    acc_d        = acc_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    a_d          = a_q;
    b_d          = b_q;
    bus.req_ready = '0;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          bus.req_ready = NREQ'(1) << grant_idx;
          a_d           = 8'(bus.req_a >> {grant_idx, 3'b000});
          b_d           = 8'(bus.req_b >> {grant_idx, 3'b000});
          id_d          = grant_idx;
          last_grant_d  = grant_idx;
          acc_d         = 16'h0000;
          step_d        = 2'd0;
          state_d       = MUL;
        end
      end
      MUL: begin
        acc_d  = acc_q + partial;
        step_d = step_q + 2'd1;
        if (step_q == 2'd3) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      step_q       <= 2'd0;
      acc_q        <= 16'h0000;
      last_grant_q <= ID_W'(NREQ - 1);
      id_q         <= '0;
      a_q          <= 8'h00;
      b_q          <= 8'h00;
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      acc_q        <= acc_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      a_q          <= a_d;
      b_q          <= b_d;
    end
  end

  assign bus.res_valid = (state_q == DONE);
  assign bus.res_prod  = (state_q == DONE) ? acc_q : 16'h0000;
  assign bus.res_id    = (state_q == DONE) ? id_q : '0;
  assign busy          = (state_q != IDLE);
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_mult4_share_seq.sv
// Directed bench: NREQ=2 instance for function, backpressure and reset abort,
// NREQ=4 instance for grant rotation and request spacing.
module tb_mult4_share_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       busy0, busy4;
  logic [1:0] st0, st4;

  int checks = 0;
  int errors = 0;
  logic [17:0] exp_q[$];

  always #5 clk = ~clk;

  mult4_share_seq_if #(.NREQ(2), .ID_W(2)) if0 ();
  mult4_share_seq_if #(.NREQ(4), .ID_W(2)) if4 ();

  mult4_share_seq #(.NREQ(2), .ID_W(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0.slave), .busy(busy0), .dbg_state(st0)
  );
  mult4_share_seq #(.NREQ(4), .ID_W(2)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .bus(if4.slave), .busy(busy4), .dbg_state(st4)
  );

  // Behavioural stand-ins for the shared multiplier core.
  assign if0.core_o = 8'(if0.core_x) * 8'(if0.core_y);
  assign if4.core_o = 8'(if4.core_x) * 8'(if4.core_y);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Scoreboard: every result handshake on the NREQ=2 instance pops one expectation.
  initial begin
    logic [17:0] e;
    forever begin
      @(negedge clk);
      #3;
      if (rst_n && if0.res_valid && if0.res_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_result", 32'(if0.res_prod), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check_eq("res_prod", 32'(if0.res_prod), 32'(e[15:0]));
          check_eq("res_id", 32'(if0.res_id), 32'(e[17:16]));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  // Present one request, check grant and core operand sequence, stop at the DONE cycle.
  task automatic do_job(input int who, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp_prod);
    int n;
    logic [3:0] xe, ye;
    if0.req_a[8*who +: 8] = a;
    if0.req_b[8*who +: 8] = b;
    if0.req_valid[who]    = 1'b1;
    #1;
    n = 0;
    while (if0.req_ready == 2'b00 && n < 30) begin
      tick();
      n++;
    end
    check_eq("grant", 32'(if0.req_ready), 32'(1) << who);
    exp_q.push_back({2'(who), exp_prod});
    tick();
    if0.req_valid[who] = 1'b0;
    for (int s = 0; s < 4; s++) begin
      xe = (s % 2 == 1) ? a[7:4] : a[3:0];
      ye = (s >= 2) ? b[7:4] : b[3:0];
      check_eq($sformatf("core_x_s%0d", s), 32'(if0.core_x), 32'(xe));
      check_eq($sformatf("core_y_s%0d", s), 32'(if0.core_y), 32'(ye));
      check_eq("busy_mul", 32'(busy0), 32'd1);
      tick();
    end
    check_eq("res_valid_done", 32'(if0.res_valid), 32'd1);
  endtask

  initial begin
    int gap;
    int n;
    logic [15:0] prod4_exp;
    if0.req_valid = '0; if0.req_a = '0; if0.req_b = '0; if0.res_ready = 1'b1;
    if4.req_valid = '0; if4.req_a = '0; if4.req_b = '0; if4.res_ready = 1'b1;

    // Reset values
    repeat (2) tick();
    check_eq("rst_res_valid", 32'(if0.res_valid), 32'd0);
    check_eq("rst_res_prod", 32'(if0.res_prod), 32'd0);
    check_eq("rst_res_id", 32'(if0.res_id), 32'd0);
    check_eq("rst_req_ready", 32'(if0.req_ready), 32'd0);
    check_eq("rst_core_x", 32'(if0.core_x), 32'd0);
    check_eq("rst_core_y", 32'(if0.core_y), 32'd0);
    check_eq("rst_busy", 32'(busy0), 32'd0);
    check_eq("rst_state", 32'(st0), 32'd0);
    rst_n = 1'b1;
    tick();

    // Single request 0xFF*0xFF; core pairs F/F x4
    do_job(0, 8'hFF, 8'hFF, 16'hFE01);
    tick();
    check_eq("idle_after_t1", 32'(busy0), 32'd0);

    // req1 0x3C*0xA5 (pairs C/5, 3/5, C/A, 3/A) held in DONE by backpressure
    if0.res_ready = 1'b0;
    do_job(1, 8'h3C, 8'hA5, 16'h26AC);
    if0.req_a[7:0] = 8'h11;
    if0.req_b[7:0] = 8'h11;
    if0.req_valid[0] = 1'b1;
    repeat (10) begin
      tick();
      check_eq("bp_res_valid", 32'(if0.res_valid), 32'd1);
      check_eq("bp_res_prod", 32'(if0.res_prod), 32'h26AC);
      check_eq("bp_res_id", 32'(if0.res_id), 32'd1);
      check_eq("bp_busy", 32'(busy0), 32'd1);
      check_eq("bp_req_ready", 32'(if0.req_ready), 32'd0);
    end
    if0.res_ready = 1'b1;
    tick();
    check_eq("bp_release_valid", 32'(if0.res_valid), 32'd0);
    check_eq("bp_release_busy", 32'(busy0), 32'd0);
    check_eq("bp_release_grant", 32'(if0.req_ready), 32'd1);
    do_job(0, 8'h11, 8'h11, 16'h0121);
    tick();

    // Both valid from reset: grants alternate 0,1,0,1 six cycles apart
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    if0.req_a = {8'h00, 8'h12};
    if0.req_b = {8'h7F, 8'h34};
    if0.req_valid = 2'b11;
    #1;
    for (int g = 0; g < 4; g++) begin
      gap = 0;
      if (g > 0) begin
        do begin
          tick();
          gap++;
        end while (if0.req_ready == 2'b00 && gap < 20);
        check_eq("alt_gap", 32'(gap), 32'd6);
      end
      check_eq($sformatf("alt_grant%0d", g), 32'(if0.req_ready), 32'(1) << (g % 2));
      if (g % 2 == 0) exp_q.push_back({2'd0, 16'h03A8});
      else            exp_q.push_back({2'd1, 16'h0000});
    end
    tick();
    if0.req_valid = 2'b00;
    repeat (6) tick();

    // Reset at MUL step2 aborts the job; arbitration restarts from requester 0
    if0.req_a[7:0] = 8'hAA;
    if0.req_b[7:0] = 8'h55;
    if0.req_valid[0] = 1'b1;
    #1;
    n = 0;
    while (if0.req_ready == 2'b00 && n < 20) begin
      tick();
      n++;
    end
    check_eq("abort_grant", 32'(if0.req_ready), 32'd1);
    tick();
    if0.req_valid[0] = 1'b0;
    repeat (2) tick();
    check_eq("abort_core_x_s2", 32'(if0.core_x), 32'hA);
    check_eq("abort_core_y_s2", 32'(if0.core_y), 32'h5);
    rst_n = 1'b0;
    #1;
    check_eq("abort_busy", 32'(busy0), 32'd0);
    check_eq("abort_core_x", 32'(if0.core_x), 32'd0);
    check_eq("abort_core_y", 32'(if0.core_y), 32'd0);
    check_eq("abort_res_valid", 32'(if0.res_valid), 32'd0);
    check_eq("abort_state", 32'(st0), 32'd0);
    tick();
    rst_n = 1'b1;
    if0.req_a[15:8] = 8'h05;
    if0.req_b[15:8] = 8'h07;
    if0.req_valid[1] = 1'b1;
    do_job(0, 8'h02, 8'h03, 16'h0006);
    tick();
    do_job(1, 8'h05, 8'h07, 16'h0023);
    tick();

    // NREQ=4, all valid: grants 0,1,2,3,0 six cycles apart; product of requester i is (i+1)*0x10
    if4.req_a = {8'h04, 8'h03, 8'h02, 8'h01};
    if4.req_b = {8'h10, 8'h10, 8'h10, 8'h10};
    if4.req_valid = 4'hF;
    #1;
    prod4_exp = 16'h0000;
    for (int g = 0; g < 5; g++) begin
      gap = 0;
      if (g > 0) begin
        do begin
          tick();
          gap++;
          if (if4.res_valid) check_eq("n4_res_prod", 32'(if4.res_prod), 32'(prod4_exp));
        end while (if4.req_ready == 4'h0 && gap < 20);
        check_eq("n4_gap", 32'(gap), 32'd6);
      end
      check_eq($sformatf("n4_grant%0d", g), 32'(if4.req_ready), 32'(1) << (g % 4));
      prod4_exp = 16'((g % 4 + 1) * 16);
    end
    tick();
    if4.req_valid = 4'h0;
    repeat (6) tick();
    check_eq("n4_idle_busy", 32'(busy4), 32'd0);
    check_eq("n4_idle_state", 32'(st4), 32'd0);
    check_eq("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult4_share_seq.md
Name: mult4_share_seq

Overview:
- Sequencer and arbiter that computes 8x8 unsigned products on one shared 4x4 combinational multiplier core.
- The core has 4-bit x/y inputs and an 8-bit o output.
- Arbitrates round-robin among NREQ requesters using valid/ready handshakes.
- Issues the four nibble partial products over four cycles, accumulates them, and returns a 16-bit product tagged with the requester id.
- Sits between requesting units and the single multiplier instance; the core itself is instantiated outside this block.

Parameters:
- NREQ, 2, number of requesters (legal 2..4).
- ID_W, 2, width of res_id (fixed at 2).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NREQ  per-requester request valid.
- req_a  input  8*NREQ  operand A; requester i uses bits [8i+7:8i].
- req_b  input  8*NREQ  operand B; same packing as req_a.
- req_ready  output  NREQ  per-requester accept; at most one bit high.
- res_valid  output  1  result valid.
- res_ready  input  1  result consumer ready.
- res_prod  output  16  product A*B.
- res_id  output  ID_W  index of the requester that owns res_prod.
- core_x  output  4  drives the shared multiplier x input.
- core_y  output  4  drives the shared multiplier y input.
- core_o  input  8  shared multiplier product, combinational from core_x/core_y.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (async, rst_n low) clears everything:
  - state=IDLE, step=0, acc=0, last_grant=NREQ-1, captured operands=0.
  - Outputs: res_valid=0, res_prod=0, res_id=0, req_ready=0, core_x=0, core_y=0, busy=0.
- States: IDLE, MUL, DONE.
- IDLE:
  - Round-robin search starts at (last_grant+1) mod NREQ and picks the first i with req_valid[i]=1.
  - req_ready[i]=1 for that i only; this is combinational from req_valid and last_grant, valid only in IDLE.
  - On the clock edge where req_valid[i]&req_ready[i]: capture A, B and id=i; set last_grant=i, acc=0, step=0; go to MUL.
  - No valid request: stay in IDLE; all req_ready=0.
- MUL, one step per cycle; core_x/core_y are registered-state decodes, stable for the whole cycle:
  - step0: x=A[3:0], y=B[3:0], acc += core_o<<0
  - step1: x=A[7:4], y=B[3:0], acc += core_o<<4
  - step2: x=A[3:0], y=B[7:4], acc += core_o<<4
  - step3: x=A[7:4], y=B[7:4], acc += core_o<<8; then go to DONE.
  - acc is 16 bits; the maximum 0xFF*0xFF=0xFE01 cannot overflow, so no carry out is kept.
- DONE:
  - res_valid=1; res_prod=acc and res_id=id, both held stable until handshake.
  - On res_valid&res_ready: go to IDLE; res_valid falls next cycle.
  - res_ready low: hold indefinitely with no change to any output.
- core_x/core_y = 0 in IDLE and DONE.
- Timing:
  - Accept edge = cycle 0; res_valid is high after edge 4, i.e. 4 cycles after acceptance.
  - Minimum request-to-request interval is 6 cycles (IDLE, 4xMUL, DONE). No overlap between jobs.
- Arbitration:
  - req_ready=0 for every requester while busy.
  - Requests asserted during MUL/DONE wait; requesters must hold valid and operands until accepted.
  - Round-robin pointer advances only on acceptance.
  - With all requesters continuously valid, grants rotate 0,1,..,NREQ-1,0.
- Zero operands run the full 4 steps; there is no early-out.
- Reset mid-MUL or mid-DONE: the job is dropped, no result is produced, and last_grant returns to NREQ-1.

Test Plan:
- Single request, req0 A=0xFF B=0xFF, res_ready=1:
  - req_ready[0] high in cycle 0.
  - core_x/core_y sequence F/F, F/F, F/F, F/F.
  - res_valid high 4 cycles after acceptance, res_prod=0xFE01, res_id=0.
- req1 A=0x3C B=0xA5:
  - core pairs C/5, 3/5, C/A, 3/A.
  - res_prod=0x26AC, res_id=1.
- Both requesters valid from reset, req0 0x12*0x34, req1 0x00*0x7F:
  - Served req0 first (0x03A8, id0), then req1 (0x0000, id1).
  - Grants alternate 0,1,0,1 while both stay valid.
- Backpressure: res_ready=0 for 10 cycles in DONE:
  - res_valid, res_prod and res_id stay stable, busy=1, req_ready=0.
  - Release res_ready: one handshake, then IDLE.
- Assert rst_n=0 at MUL step2, release it, and issue req0 0x02*0x03:
  - Outputs clear asynchronously; no res_valid from the aborted job.
  - Next grant goes to req0; res_prod=0x0006.
- NREQ=4, all valid:
  - Grant order 0,1,2,3,0.
  - Spacing between consecutive req_ready pulses is exactly 6 cycles with res_ready tied high.
